cache_arbiter: RTL and testbench
================================

# cache_arbiter

Arbitrates the single physical-memory port between the instruction-cache miss path and the data-cache miss/writeback path of the pipelined RV32I core. Each cache issues at most one cacheline transaction at a time. The arbiter grants one requester, latches its address and data, and drives the shared memory port until it responds. It then returns the line and a one-cycle response pulse to the owner. Simultaneous requests are resolved round-robin, so a stream of data misses cannot starve instruction fetch.

## Interface
- LINE_WIDTH, 256, cacheline width in bits
- ADDR_WIDTH, 32, byte address width; line-aligned addresses are passed through unmodified
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset; asynchronous, active-high
- i_read  in  1  I-side line read request; held until i_resp
- i_address  in  ADDR_WIDTH  I-side line address; stable while i_read high
- i_rdata  out  LINE_WIDTH  returned line; valid in the i_resp cycle and held until the next I completion
- i_resp  out  1  one-cycle completion pulse to I side
- d_read  in  1  D-side line read request; held until d_resp
- d_write  in  1  D-side line write (writeback) request; held until d_resp
- d_address  in  ADDR_WIDTH  D-side line address
- d_wdata  in  LINE_WIDTH  D-side writeback data; stable while d_write high
- d_rdata  out  LINE_WIDTH  returned line for D reads; held like i_rdata
- d_resp  out  1  one-cycle completion pulse to D side
- pmem_read  out  1  memory read strobe; held until pmem_resp
- pmem_write  out  1  memory write strobe; held until pmem_resp
- pmem_address  out  ADDR_WIDTH  latched address of the granted request
- pmem_wdata  out  LINE_WIDTH  latched writeback data
- pmem_rdata  in  LINE_WIDTH  memory read data; valid with pmem_resp
- pmem_resp  in  1  memory completion, one cycle

## Operation
- State machine:
  - IDLE → I_BUSY on an I grant; IDLE → D_BUSY on a D grant; IDLE stays put with no request.
  - I_BUSY or D_BUSY → DONE on pmem_resp.
  - DONE → IDLE, unconditionally.
- Grant decision, IDLE only:
  - A requester is pending when i_read is high (I) or d_read|d_write is high (D).
  - One requester pending: grant it.
  - Both pending: grant the side opposite last_grant.
  - last_grant is a 1-bit register updated on every grant. Reset value is I, so the first tie goes to D.
- On grant, latch into registers:
  - pmem_address from the granted address.
  - pmem_wdata from d_wdata on a D write; otherwise unchanged.
  - pmem_read, or pmem_write for a D write.
- d_read and d_write both high: treated as a write. The read is not serviced and no error is flagged.
- In a BUSY state, pmem_resp clears pmem_read/pmem_write. For reads it also latches pmem_rdata into the owner's rdata register.
- DONE asserts the owner's resp for exactly one cycle. The non-owner's resp stays 0.
- DONE exists so that a request still high in the completion cycle is never re-granted. The requester deasserts, or issues a new request, starting the cycle after resp.
- pmem_resp seen in IDLE or DONE is ignored: no state, data or strobe change.
- Requests arriving while busy are not sampled. They wait, held by the requester, for the next IDLE.

## Timing
- Reset (async assert) values:
  - state=IDLE, last_grant=I.
  - pmem_read=pmem_write=0, i_resp=d_resp=0.
  - pmem_address=0, pmem_wdata=0, i_rdata=d_rdata=0.
- Reset asserted mid-transaction: the transaction is aborted, with no resp to either side. A pmem_resp arriving after reset deasserts lands in IDLE and is ignored.
- Latency, request seen in IDLE at cycle 0:
  - Cycle 1: pmem strobe high.
  - Cycle k: pmem_resp.
  - Cycle k+1: owner resp and rdata valid.
  - Cycle k+2: IDLE.
- Earliest next grant is sampled in the IDLE cycle k+2; the next pmem strobe appears in cycle k+3. Minimum occupancy is 4 cycles per transaction when pmem responds the cycle after the strobe.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Single I read: i_read=1, i_address=0x0000_0060, pmem_resp 3 cycles after pmem_read with rdata=0xA5…A5 → pmem_address=0x60 and pmem_read=1 from cycle 1; i_resp a single pulse with i_rdata=0xA5…A5; d_resp never asserted.
- D writeback: d_write=1, d_address=0x0000_1000, d_wdata pattern P → pmem_write=1, pmem_wdata=P, pmem_read=0; d_resp one pulse after pmem_resp; d_rdata unchanged.
- Tie alternation: i_read and d_read held high continuously, each requester reissuing immediately after its resp → grant order D, I, D, I; no back-to-back grants to the same side.
- Late arrival: d_read rises while I_BUSY → D is not granted until IDLE after I's DONE; I transaction completes unchanged.
- Reset mid-transaction: assert rst while D_BUSY, then pmem_resp after release → all outputs 0 immediately on rst; no d_resp; state stays IDLE.
- Spurious response: pmem_resp pulse in IDLE with no requests → no strobes, no resp, rdata registers unchanged.

Source files
------------

// File: rtl/cache_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : cache_arbiter_if
// Brief    : Bundles the I-cache, D-cache and physical-memory ports of the
//            cache arbiter; slave = arbiter view, master = environment view.
// Revision : 1.0 - initial release
// ============================================================================
interface cache_arbiter_if #(
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32
);
    logic                  i_read;
    logic [ADDR_WIDTH-1:0] i_address;
    logic [LINE_WIDTH-1:0] i_rdata;
    logic                  i_resp;

    logic                  d_read;
    logic                  d_write;
    logic [ADDR_WIDTH-1:0] d_address;
    logic [LINE_WIDTH-1:0] d_wdata;
    logic [LINE_WIDTH-1:0] d_rdata;
    logic                  d_resp;

    logic                  pmem_read;
    logic                  pmem_write;
    logic [ADDR_WIDTH-1:0] pmem_address;
    logic [LINE_WIDTH-1:0] pmem_wdata;
    logic [LINE_WIDTH-1:0] pmem_rdata;
    logic                  pmem_resp;

    modport slave (
        input  i_read, i_address,
        output i_rdata, i_resp,
        input  d_read, d_write, d_address, d_wdata,
        output d_rdata, d_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output i_read, i_address,
        input  i_rdata, i_resp,
        output d_read, d_write, d_address, d_wdata,
        input  d_rdata, d_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );
endinterface
`default_nettype wire

// File: rtl/cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cache_arbiter
// Brief    : Round-robin arbiter sharing one physical-memory port between the
//            I-cache miss path and the D-cache miss/writeback path.
// Revision : 1.0 - initial release
// ============================================================================
module cache_arbiter #(
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    cache_arbiter_if.slave bus
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_I_BUSY = 2'd1;
    localparam logic [1:0] c_D_BUSY = 2'd2;
    localparam logic [1:0] c_DONE   = 2'd3;

    localparam logic c_GRANT_I = 1'b0;
    localparam logic c_GRANT_D = 1'b1;

    logic [1:0]            r_state;
    logic                  r_last_grant;
    logic                  r_pmem_read;
    logic                  r_pmem_write;
    logic [ADDR_WIDTH-1:0] r_pmem_address;
    logic [LINE_WIDTH-1:0] r_pmem_wdata;
    logic [LINE_WIDTH-1:0] r_i_rdata;
    logic [LINE_WIDTH-1:0] r_d_rdata;
    logic                  r_i_resp;
    logic                  r_d_resp;

    logic w_i_pend;
    logic w_d_pend;
    logic w_grant_i;
    logic w_grant_d;

    assign w_i_pend  = bus.i_read;
    assign w_d_pend  = bus.d_read | bus.d_write;
    // On a tie the side that did not win last time goes first.
    assign w_grant_d = w_d_pend & (~w_i_pend | (r_last_grant == c_GRANT_I));
    assign w_grant_i = w_i_pend & ~w_grant_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= c_IDLE;
            r_last_grant   <= c_GRANT_I;
            r_pmem_read    <= 1'b0;
            r_pmem_write   <= 1'b0;
            r_pmem_address <= '0;
            r_pmem_wdata   <= '0;
            r_i_rdata      <= '0;
            r_d_rdata      <= '0;
            r_i_resp       <= 1'b0;
            r_d_resp       <= 1'b0;
        end else begin
            r_i_resp <= 1'b0;
            r_d_resp <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_grant_d) begin
                        r_state        <= c_D_BUSY;
                        r_last_grant   <= c_GRANT_D;
                        r_pmem_address <= bus.d_address;
                        // A simultaneous read+write is serviced as the writeback.
                        if (bus.d_write) begin
                            r_pmem_write <= 1'b1;
                            r_pmem_wdata <= bus.d_wdata;
                        end else begin
                            r_pmem_read  <= 1'b1;
                        end
                    end else if (w_grant_i) begin
                        r_state        <= c_I_BUSY;
                        r_last_grant   <= c_GRANT_I;
                        r_pmem_address <= bus.i_address;
                        r_pmem_read    <= 1'b1;
                    end
                end
                c_I_BUSY: begin
                    if (bus.pmem_resp) begin
                        r_state      <= c_DONE;
                        r_pmem_read  <= 1'b0;
                        r_pmem_write <= 1'b0;
                        r_i_rdata    <= bus.pmem_rdata;
                        r_i_resp     <= 1'b1;
                    end
                end
                c_D_BUSY: begin
                    if (bus.pmem_resp) begin
                        r_state      <= c_DONE;
                        r_pmem_read  <= 1'b0;
                        r_pmem_write <= 1'b0;
                        if (r_pmem_read) begin
                            r_d_rdata <= bus.pmem_rdata;
                        end
                        r_d_resp     <= 1'b1;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.pmem_read    = r_pmem_read;
    assign bus.pmem_write   = r_pmem_write;
    assign bus.pmem_address = r_pmem_address;
    assign bus.pmem_wdata   = r_pmem_wdata;
    assign bus.i_rdata      = r_i_rdata;
    assign bus.i_resp       = r_i_resp;
    assign bus.d_rdata      = r_d_rdata;
    assign bus.d_resp       = r_d_resp;

endmodule
`default_nettype wire

// File: tb/tb_cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_arbiter
// Brief    : Randomized I/D traffic against a transaction-level round-robin
//            model, with a response scoreboard and directed reset cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_arbiter;

    localparam int LW   = 256;
    localparam int AW   = 32;
    localparam int NTX  = 40;
    localparam int TMO  = 200;

    typedef struct packed {
        logic          to_d;
        logic          is_write;
        logic [LW-1:0] data;
    } sb_t;

    logic clk;
    logic rst;

    cache_arbiter_if #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) bus ();

    cache_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int      n_vec = 0;
    int      n_err = 0;
    sb_t     sb[$];
    logic    mon_en = 1'b0;
    logic    prev_resp = 1'b0;
    logic    prev_i = 1'b0;
    logic    prev_d = 1'b0;
    logic    model_last_d = 1'b0;
    logic    i_done = 1'b0;
    logic    d_done = 1'b0;
    logic [LW-1:0] shadow_i = '0;
    logic [LW-1:0] shadow_d = '0;
    logic [AW-1:0] cur_i_addr = '0;
    logic [AW-1:0] cur_d_addr = '0;
    logic [LW-1:0] cur_d_wdata = '0;
    logic          cur_d_write = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_pmem_read"},  bus.pmem_read,    0);
        chk({nm, "_pmem_write"}, bus.pmem_write,   0);
        chk({nm, "_pmem_addr"},  bus.pmem_address, 0);
        chk({nm, "_pmem_wdata"}, bus.pmem_wdata,   0);
        chk({nm, "_i_resp"},     bus.i_resp,       0);
        chk({nm, "_d_resp"},     bus.d_resp,       0);
        chk({nm, "_i_rdata"},    bus.i_rdata,      0);
        chk({nm, "_d_rdata"},    bus.d_rdata,      0);
    endtask

    // Request levels as seen by the arbiter at each rising edge.
    always @(posedge clk) begin
        prev_i <= bus.i_read;
        prev_d <= bus.d_read | bus.d_write;
    end

    // Response monitor / scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.i_resp || bus.d_resp) begin
                chk("resp_exclusive", bus.i_resp & bus.d_resp, 0);
                chk("resp_single_cycle", prev_resp, 0);
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL resp_unexpected: i_resp=%0b d_resp=%0b required none outstanding",
                             bus.i_resp, bus.d_resp);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    chk("resp_owner_d", bus.d_resp, e.to_d);
                    if (e.to_d) begin
                        if (!e.is_write) shadow_d = e.data;
                        chk("d_rdata", bus.d_rdata, shadow_d);
                        chk("i_rdata_hold", bus.i_rdata, shadow_i);
                    end else begin
                        shadow_i = e.data;
                        chk("i_rdata", bus.i_rdata, shadow_i);
                        chk("d_rdata_hold", bus.d_rdata, shadow_d);
                    end
                end
            end
            prev_resp = bus.i_resp | bus.d_resp;
        end
    end

    initial begin
        rst             = 1'b1;
        bus.i_read      = 1'b0;
        bus.i_address   = '0;
        bus.d_read      = 1'b0;
        bus.d_write     = 1'b0;
        bus.d_address   = '0;
        bus.d_wdata     = '0;
        bus.pmem_rdata  = '0;
        bus.pmem_resp   = 1'b0;

        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // Spurious memory response while idle.
        @(posedge clk); #1;
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = {LW{1'b1}};
        @(negedge clk);
        chk_all_zero("spurious0");
        @(posedge clk); #1;
        bus.pmem_resp = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk_all_zero("spurious");
        end

        @(posedge clk); #1;
        fork
            begin : req_i
                for (int n = 0; n < NTX; n++) begin
                    int gap;
                    int t;
                    gap = $urandom_range(0, 3);
                    repeat (gap) @(posedge clk);
                    #1;
                    cur_i_addr    = {1'b0, 26'($urandom), 5'b0};
                    bus.i_address = cur_i_addr;
                    bus.i_read    = 1'b1;
                    t = 0;
                    do begin @(negedge clk); t++; end while (!bus.i_resp && t < TMO);
                    if (!bus.i_resp) begin
                        n_vec++; n_err++;
                        $display("FAIL i_timeout: no i_resp after %0d cycles", t);
                    end
                    @(posedge clk); #1;
                    bus.i_read = 1'b0;
                end
                i_done = 1'b1;
            end
            begin : req_d
                for (int n = 0; n < NTX; n++) begin
                    int gap;
                    int kind;
                    int t;
                    gap  = $urandom_range(0, 3);
                    kind = $urandom_range(0, 2);
                    repeat (gap) @(posedge clk);
                    #1;
                    cur_d_addr    = {1'b1, 26'($urandom), 5'b0};
                    cur_d_wdata   = rand_line();
                    cur_d_write   = (kind != 0);
                    bus.d_address = cur_d_addr;
                    bus.d_wdata   = cur_d_wdata;
                    bus.d_read    = (kind != 1);
                    bus.d_write   = (kind != 0);
                    t = 0;
                    do begin @(negedge clk); t++; end while (!bus.d_resp && t < TMO);
                    if (!bus.d_resp) begin
                        n_vec++; n_err++;
                        $display("FAIL d_timeout: no d_resp after %0d cycles", t);
                    end
                    @(posedge clk); #1;
                    bus.d_read  = 1'b0;
                    bus.d_write = 1'b0;
                end
                d_done = 1'b1;
            end
            begin : mem
                while (!(i_done && d_done)) begin
                    @(negedge clk);
                    if (bus.pmem_read || bus.pmem_write) begin
                        logic          exp_d;
                        logic          exp_wr;
                        logic [LW-1:0] rdat;
                        int            lat;
                        if (!prev_i && !prev_d) begin
                            n_vec++; n_err++;
                            $display("FAIL grant_no_req: strobe with no request pending");
                        end
                        exp_d        = prev_d && (!prev_i || !model_last_d);
                        model_last_d = exp_d;
                        exp_wr       = exp_d && cur_d_write;
                        chk("grant_addr", bus.pmem_address, exp_d ? cur_d_addr : cur_i_addr);
                        chk("grant_write", bus.pmem_write, exp_wr);
                        chk("grant_read", bus.pmem_read, !exp_wr);
                        if (exp_wr) chk("grant_wdata", bus.pmem_wdata, cur_d_wdata);
                        lat  = $urandom_range(0, 3);
                        rdat = rand_line();
                        @(posedge clk);
                        repeat (lat) @(posedge clk);
                        #1;
                        bus.pmem_resp  = 1'b1;
                        bus.pmem_rdata = rdat;
                        sb.push_back('{to_d: exp_d, is_write: exp_wr, data: rdat});
                        @(posedge clk); #1;
                        bus.pmem_resp  = 1'b0;
                        bus.pmem_rdata = rand_line();
                        @(negedge clk);
                        chk("done_resp", exp_d ? bus.d_resp : bus.i_resp, 1);
                        chk("done_strobe", bus.pmem_read | bus.pmem_write, 0);
                    end
                end
            end
        join
        chk("sb_drained", sb.size(), 0);

        // Reset asserted in the middle of a D transaction.
        repeat (3) @(posedge clk);
        #1;
        bus.d_address = 32'h8000_1000;
        bus.d_wdata   = rand_line();
        bus.d_write   = 1'b1;
        begin
            int t;
            t = 0;
            do begin @(negedge clk); t++; end while (!bus.pmem_write && t < TMO);
            chk("rst_mid_strobe", bus.pmem_write, 1);
        end
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk_all_zero("rst_mid");
        shadow_i = '0;
        shadow_d = '0;
        bus.d_write = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = rand_line();
        @(posedge clk); #1;
        bus.pmem_resp = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk_all_zero("rst_after");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
